// File: rtl/exmem_skid_pipeline_pkg.sv
// exmem_skid_pipeline_pkg: shared memctl bit positions, FSM state encoding and payload layout
package exmem_skid_pipeline_pkg;
    localparam int MEMCTL_LOAD  = 0;
    localparam int MEMCTL_STORE = 1;
    localparam int MEMCTL_BYTE  = 2;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_REG_IDX_W = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Payload layout at the default widths; the top packs the same field order into a flat vector
    typedef struct packed {
        logic [DEF_DATA_W-1:0]    alu1;
        logic [DEF_DATA_W-1:0]    alu2;
        logic [DEF_REG_IDX_W-1:0] rd1;
        logic [DEF_REG_IDX_W-1:0] rd2;
        logic                     wen1;
        logic                     wen2;
        logic [DEF_DATA_W-1:0]    store_data;
        logic [2:0]               memctl;
    } payload_t;

    function automatic int payload_w(input int dw, input int rw);
        return 3 * dw + 2 * rw + 5;
    endfunction
endpackage

// File: rtl/exmem_payload_reg.sv
// exmem_payload_reg: one payload entry with load enable, cleared by async active-low reset
module exmem_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    // capture new entry when load is asserted
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_q <= '0;
        else if (i_load) r_q <= i_d;

    assign o_q = r_q;
endmodule

// File: rtl/exmem_skid_pipeline.sv
// exmem_skid_pipeline: two-entry EX/MEM skid buffer with registered ready; optional EXMEM_STALL_CNT_EN stall counter
module exmem_skid_pipeline
    import exmem_skid_pipeline_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_IDX_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_alu1,
    input  logic [DATA_W-1:0]    in_alu2,
    input  logic [REG_IDX_W-1:0] in_rd1,
    input  logic [REG_IDX_W-1:0] in_rd2,
    input  logic                 in_wen1,
    input  logic                 in_wen2,
    input  logic [DATA_W-1:0]    in_store_data,
    input  logic [2:0]           in_memctl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_alu1,
    output logic [DATA_W-1:0]    out_alu2,
    output logic [REG_IDX_W-1:0] out_rd1,
    output logic [REG_IDX_W-1:0] out_rd2,
    output logic                 out_wen1,
    output logic                 out_wen2,
    output logic [DATA_W-1:0]    out_store_data,
    output logic [2:0]           out_memctl
`ifdef EXMEM_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);
    localparam int PW = payload_w(DATA_W, REG_IDX_W);

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  w_acc;
    logic                  w_main_load;
    logic                  w_skid_load;
    logic [PW-1:0]         w_in_pl;
    logic [PW-1:0]         w_main_d;
    logic [PW-1:0]         w_main_q;
    logic [PW-1:0]         w_skid_q;
    logic [DATA_W-1:0]     w_alu1;
    logic [DATA_W-1:0]     w_alu2;
    logic [REG_IDX_W-1:0]  w_rd1;
    logic [REG_IDX_W-1:0]  w_rd2;
    logic                  w_wen1;
    logic                  w_wen2;
    logic [DATA_W-1:0]     w_sd;
    logic [2:0]            w_mc;

    assign w_in_pl = {in_alu1, in_alu2, in_rd1, in_rd2, in_wen1, in_wen2, in_store_data, in_memctl};
    assign w_acc   = in_valid && r_in_ready;

    // main refills from the input, or from skid when draining TWO; skid only fills on a stalled accept
    always_comb begin
        w_main_load = !flush && ((r_state == EMPTY && w_acc) ||
                                 (r_state == ONE && w_acc && out_ready) ||
                                 (r_state == TWO && out_ready));
        w_skid_load = !flush && r_state == ONE && w_acc && !out_ready;
        w_main_d    = (r_state == TWO) ? w_skid_q : w_in_pl;
    end

    // occupancy FSM with registered in_ready / out_valid; flush squashes everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: if (w_acc) begin
                    r_state     <= ONE;
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                end
                ONE: if (w_acc && !out_ready) begin
                    r_state     <= TWO;
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b0;
                end else if (!w_acc && out_ready) begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
                TWO: if (out_ready) begin
                    r_state     <= ONE;
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    exmem_payload_reg #(.W(PW)) u_main (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    exmem_payload_reg #(.W(PW)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_skid_load),
        .i_d    (w_in_pl),
        .o_q    (w_skid_q)
    );

    assign {w_alu1, w_alu2, w_rd1, w_rd2, w_wen1, w_wen2, w_sd, w_mc} = w_main_q;

    assign in_ready       = r_in_ready;
    assign out_valid      = r_out_valid;
    assign out_alu1       = w_alu1;
    assign out_alu2       = w_alu2;
    assign out_rd1        = w_rd1;
    assign out_rd2        = w_rd2;
    assign out_store_data = w_sd;
    assign out_wen1       = w_wen1 && r_out_valid;
    assign out_wen2       = w_wen2 && r_out_valid;
    assign out_memctl     = w_mc & {3{r_out_valid}};

`ifdef EXMEM_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // saturating count of cycles the memory stage holds off a valid pair; flush does not clear it
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_stall_cnt <= 16'h0;
        else if (r_out_valid && !out_ready && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'h1;

    assign stall_cnt = r_stall_cnt;
`endif
endmodule
